mem_req_sequencer: RTL and testbench

Upstream stage that drives my_mem. It buffers write/read requests from the traffic source in a small FIFO and issues them to my_mem one at a time on the write/read strobes. It captures the 9-bit read data (8 data bits plus a parity bit), checks parity, and returns read responses over a valid/ready handshake.

---
 rtl/mem_req_sequencer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_mem_req_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_sequencer.sv
// mem_req_sequencer: request front-end for my_mem.
//
// Write and read requests are buffered in a small FIFO. They are then issued to
// my_mem one at a time as single-cycle mem_write/mem_read strobes. Read data
// (8 data bits plus an even-parity bit) is captured after RD_LATENCY cycles.
// It is returned on a valid/ready response channel together with a parity-error
// flag. Only one read is ever in flight. No new command is issued while a
// response is waiting for the consumer.
//
// Parameters:
//   FIFO_DEPTH  request FIFO entries (power of 2, >= 2)
//   RD_LATENCY  cycles from a sampled mem_read to valid mem_data_out (>= 1)
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_write/address/data    request payload (data ignored for reads)
//   rsp_valid/rsp_ready       read response handshake
//   rsp_address/data          completed read address and data
//   rsp_parity_err            parity mismatch on this response
//   busy                      FIFO non-empty or FSM not idle
//   mem_write/mem_read        one-cycle strobes to my_mem
//   mem_address/mem_data_in   address/write data to my_mem, held between strobes
//   mem_data_out              read data from my_mem, bit 8 is parity
//   err_count                 saturating parity-error count
//
// Optional feature: define MEM_SEQ_ERR_CNT_EN to build the parity-error counter.
// When it is undefined, err_count is tied to zero.

module mem_req_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_address,
    input  logic [7:0]  req_data,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_address,
    output logic [7:0]  rsp_data,
    output logic        rsp_parity_err,

    output logic        busy,

    output logic        mem_write,
    output logic        mem_read,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_data_in,
    input  logic [8:0]  mem_data_out,

    output logic [15:0] err_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned LAT_W = $clog2(RD_LATENCY + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LATENCY);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitRd,
        StResp
    } state_e;

    state_e state_q, state_d;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [15:0]           fifo_addr_q [FIFO_DEPTH];
    logic [7:0]            fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_wr_q;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // Readiness comes from the registered count only. A pop in this cycle does
    // not make room for a push in the same cycle.
    assign req_ready = ~full;
    assign push      = req_valid & ~full;

    // Storage needs no reset. Entries are only read after they are written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= req_address;
            fifo_data_q[wr_ptr_q] <= req_data;
            fifo_wr_q[wr_ptr_q]   <= req_write;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Command / datapath registers
    // ------------------------------------------------------------------
    logic             cmd_write_q;
    logic [15:0]      mem_address_q;
    logic [7:0]       mem_data_in_q;
    logic [LAT_W-1:0] lat_cnt_q;
    logic [15:0]      rsp_address_q;
    logic [7:0]       rsp_data_q;
    logic             rsp_parity_err_q;

    logic lat_last;
    logic capture;
    logic parity_err;

    // The count was loaded with RD_LATENCY on leaving ISSUE. A value of 1 means
    // it reaches zero on this edge, so the read data is valid now.
    assign lat_last   = (lat_cnt_q == LAT_W'(1));
    assign capture    = (state_q == StWaitRd) & lat_last;
    // Even parity over all nine bits: any odd population is an error.
    assign parity_err = mem_data_out[8] ^ (^mem_data_out[7:0]);

    // mem_address/mem_data_in are loaded on the pop edge. That edge is the start
    // of ISSUE, so both hold their values in every other state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_write_q      <= 1'b0;
            mem_address_q    <= '0;
            mem_data_in_q    <= '0;
            lat_cnt_q        <= '0;
            rsp_address_q    <= '0;
            rsp_data_q       <= '0;
            rsp_parity_err_q <= 1'b0;
        end else begin
            if (pop) begin
                cmd_write_q   <= fifo_wr_q[rd_ptr_q];
                mem_address_q <= fifo_addr_q[rd_ptr_q];
                if (fifo_wr_q[rd_ptr_q]) begin
                    mem_data_in_q <= fifo_data_q[rd_ptr_q];
                end
            end

            if (state_q == StIssue) begin
                lat_cnt_q <= LAT_INIT;
            end else if (state_q == StWaitRd) begin
                lat_cnt_q <= lat_cnt_q - LAT_W'(1);
            end

            // mem_address still holds the read address while waiting.
            if (capture) begin
                rsp_address_q    <= mem_address_q;
                rsp_data_q       <= mem_data_out[7:0];
                rsp_parity_err_q <= parity_err;
            end
        end
    end

    assign mem_address    = mem_address_q;
    assign mem_data_in    = mem_data_in_q;
    assign rsp_address    = rsp_address_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_parity_err = rsp_parity_err_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = cmd_write_q ? StIdle : StWaitRd;
            end
            StWaitRd: begin
                if (lat_last) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        pop       = 1'b0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                pop = ~empty;
            end
            StIssue: begin
                mem_write = cmd_write_q;
                mem_read  = ~cmd_write_q;
            end
            StResp: begin
                rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = ~empty | (state_q != StIdle);

    // ------------------------------------------------------------------
    // Optional parity-error counter
    // ------------------------------------------------------------------
`ifdef MEM_SEQ_ERR_CNT_EN
    logic [15:0] err_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= '0;
        end else if (capture && parity_err && (err_count_q != 16'hFFFF)) begin
            err_count_q <= err_count_q + 16'd1;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Self-checking bench for mem_req_sequencer.
// Reference model: accepted requests must reach my_mem in acceptance order.
// Each read yields exactly one response, built from the memory model's word
// at that address. Parity errors are counted per delivered read.

module tb_mem_req_sequencer;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned RD_LATENCY = 1;
`ifdef MEM_SEQ_ERR_CNT_EN
    localparam bit ERR_CNT_ON = 1'b1;
`else
    localparam bit ERR_CNT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_address;
    logic [7:0]  req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_address;
    logic [7:0]  rsp_data;
    logic        rsp_parity_err;
    logic        busy;
    logic        mem_write;
    logic        mem_read;
    logic [15:0] mem_address;
    logic [7:0]  mem_data_in;
    logic [8:0]  mem_data_out;
    logic [15:0] err_count;

    mem_req_sequencer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .RD_LATENCY (RD_LATENCY)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_address    (req_address),
        .req_data       (req_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_address    (rsp_address),
        .rsp_data       (rsp_data),
        .rsp_parity_err (rsp_parity_err),
        .busy           (busy),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_address    (mem_address),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;

    // Memory contents are a fixed function of the address. Address 0x0010 is
    // overridable so directed tests can choose good or bad parity there.
    logic [8:0] ovr_val;

    function automatic logic [8:0] mem_word(input logic [15:0] a, input logic [8:0] ovr);
        logic [15:0] h;
        h = a * 16'd40503 + 16'd12345;
        if (a == 16'h0010) return ovr;
        return h[12:4];
    endfunction

    // my_mem read pipeline. Outside the valid window the word is inverted, so
    // capturing on the wrong cycle corrupts both data and parity.
    logic [RD_LATENCY-1:0]       pipe_v;
    logic [RD_LATENCY-1:0][15:0] pipe_a;

    always @(posedge clk) begin
        pipe_v <= RD_LATENCY'({pipe_v, mem_read});
        pipe_a <= (RD_LATENCY * 16)'({pipe_a, mem_address});
    end

    assign mem_data_out = pipe_v[RD_LATENCY-1] ? mem_word(pipe_a[RD_LATENCY-1], ovr_val)
                                               : ~mem_word(pipe_a[RD_LATENCY-1], ovr_val);

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } op_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        err;
    } rsp_t;

    op_t  exp_ops[$];
    rsp_t exp_rsp[$];
    int   rsp_timer;
    int   err_exp;
    int   n_total;
    int   n_pass;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mem_write"},   32'(mem_write), 0);
        chk({tag, "_mem_read"},    32'(mem_read), 0);
        chk({tag, "_mem_address"}, 32'(mem_address), 0);
        chk({tag, "_mem_data_in"}, 32'(mem_data_in), 0);
        chk({tag, "_rsp_valid"},   32'(rsp_valid), 0);
        chk({tag, "_rsp_address"}, 32'(rsp_address), 0);
        chk({tag, "_rsp_data"},    32'(rsp_data), 0);
        chk({tag, "_rsp_perr"},    32'(rsp_parity_err), 0);
        chk({tag, "_err_count"},   32'(err_count), 0);
        chk({tag, "_req_ready"},   32'(req_ready), 1);
        chk({tag, "_busy"},        32'(busy), 0);
    endtask

    // One clock with full model tracking and per-cycle checks.
    task automatic cyc();
        logic       acc;
        logic       hs;
        logic       issued;
        logic       rv_exp;
        logic [8:0] w;
        op_t        op;
        rsp_t       r;

        acc = req_valid & req_ready;
        hs  = rsp_valid & rsp_ready;
        if (acc) begin
            op.wr   = req_write;
            op.addr = req_address;
            op.data = req_data;
            exp_ops.push_back(op);
        end
        if (hs && exp_rsp.size() != 0 && rsp_timer == 0) exp_rsp.delete(0);

        tick();

        if (rsp_timer != 0) begin
            rsp_timer--;
            if (rsp_timer == 0 && exp_rsp.size() != 0 && exp_rsp[0].err && err_exp != 65535)
                err_exp++;
        end

        issued = 1'b0;
        chk("strobe_excl", 32'(mem_write & mem_read), 0);
        if (mem_write || mem_read) begin
            chk("issue_expected", 32'(exp_ops.size() != 0), 1);
            if (exp_ops.size() != 0) begin
                issued = 1'b1;
                op = exp_ops.pop_front();
                chk("issue_kind", 32'(mem_write), 32'(op.wr));
                chk("issue_addr", 32'(mem_address), 32'(op.addr));
                if (op.wr) begin
                    chk("issue_data", 32'(mem_data_in), 32'(op.data));
                end else begin
                    chk("issue_in_order", 32'(exp_rsp.size()), 0);
                    w      = mem_word(op.addr, ovr_val);
                    r.addr = op.addr;
                    r.data = w[7:0];
                    r.err  = w[8] ^ (^w[7:0]);
                    exp_rsp.push_back(r);
                    rsp_timer = RD_LATENCY + 1;
                end
            end
        end

        chk("busy", 32'(busy),
            32'(exp_ops.size() != 0 || issued || exp_rsp.size() != 0));
        chk("req_ready", 32'(req_ready), 32'(exp_ops.size() < FIFO_DEPTH));
        rv_exp = (exp_rsp.size() != 0) && (rsp_timer == 0);
        chk("rsp_valid", 32'(rsp_valid), 32'(rv_exp));
        if (rv_exp) begin
            chk("rsp_address", 32'(rsp_address), 32'(exp_rsp[0].addr));
            chk("rsp_data", 32'(rsp_data), 32'(exp_rsp[0].data));
            chk("rsp_parity_err", 32'(rsp_parity_err), 32'(exp_rsp[0].err));
        end
        chk("err_count", 32'(err_count), ERR_CNT_ON ? 32'(err_exp) : 0);
    endtask

    task automatic drain(input string tag);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (exp_ops.size() == 0 && exp_rsp.size() == 0) break;
            cyc();
        end
        cyc();
        chk({tag, "_drained_ops"}, 32'(exp_ops.size()), 0);
        chk({tag, "_drained_rsp"}, 32'(exp_rsp.size()), 0);
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    task automatic wait_rsp(input string tag);
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid) break;
            cyc();
        end
        chk({tag, "_rsp_reached"}, 32'(rsp_valid), 1);
    endtask

    task automatic send(input logic wr, input logic [15:0] a, input logic [7:0] d);
        req_valid   = 1'b1;
        req_write   = wr;
        req_address = a;
        req_data    = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t items [5];
        logic acc5;

        n_total     = 0;
        n_pass      = 0;
        rsp_timer   = 0;
        err_exp     = 0;
        ovr_val     = 9'h0A5;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_address = '0;
        req_data    = '0;
        rsp_ready   = 1'b0;
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;

        // Single write: one strobe cycle, no response.
        rsp_ready = 1'b1;
        chk("t1_req_ready", 32'(req_ready), 1);
        send(1'b1, 16'h0010, 8'hA5);
        cyc();
        req_valid = 1'b0;
        chk("t1_no_strobe_yet", 32'(mem_write), 0);
        cyc();
        chk("t1_mem_write", 32'(mem_write), 1);
        chk("t1_mem_address", 32'(mem_address), 32'h0010);
        chk("t1_mem_data_in", 32'(mem_data_in), 32'hA5);
        chk("t1_rsp_valid", 32'(rsp_valid), 0);
        cyc();
        chk("t1_one_cycle", 32'(mem_write), 0);
        chk("t1_addr_held", 32'(mem_address), 32'h0010);
        chk("t1_idle", 32'(busy), 0);

        // Read with good parity: response RD_LATENCY+2 cycles after acceptance.
        rsp_ready = 1'b0;
        ovr_val   = 9'h0A5;
        send(1'b0, 16'h0010, 8'h00);
        cyc();
        req_valid = 1'b0;
        for (int k = 1; k <= RD_LATENCY + 2; k++) begin
            cyc();
            chk($sformatf("t2_rsp_valid_c%0d", k), 32'(rsp_valid), 32'(k == RD_LATENCY + 2));
            chk($sformatf("t2_mem_read_c%0d", k), 32'(mem_read), 32'(k == 1));
        end
        chk("t2_rsp_data", 32'(rsp_data), 32'hA5);
        chk("t2_rsp_address", 32'(rsp_address), 32'h0010);
        chk("t2_rsp_perr", 32'(rsp_parity_err), 0);
        rsp_ready = 1'b1;
        cyc();
        chk("t2_rsp_done", 32'(rsp_valid), 0);

        // Read with bad parity.
        rsp_ready = 1'b0;
        ovr_val   = 9'h1A5;
        send(1'b0, 16'h0010, 8'h00);
        cyc();
        req_valid = 1'b0;
        wait_rsp("t3");
        chk("t3_rsp_data", 32'(rsp_data), 32'hA5);
        chk("t3_rsp_perr", 32'(rsp_parity_err), 1);
        chk("t3_err_count", 32'(err_count), ERR_CNT_ON ? 1 : 0);
        rsp_ready = 1'b1;
        cyc();

        // Stall in RESP, fill FIFO, hold, then drain in order.
        rsp_ready = 1'b0;
        send(1'b0, 16'h0020, 8'h00);
        cyc();
        req_valid = 1'b0;
        wait_rsp("t4");
        items[0] = '{1'b1, 16'h0100, 8'h11};
        items[1] = '{1'b0, 16'h0101, 8'h00};
        items[2] = '{1'b1, 16'h0102, 8'h33};
        items[3] = '{1'b0, 16'h0010, 8'h00};
        items[4] = '{1'b1, 16'h0104, 8'h55};
        for (int i = 0; i < 4; i++) begin
            send(items[i].wr, items[i].addr, items[i].data);
            chk($sformatf("t4_ready_push%0d", i), 32'(req_ready), 1);
            cyc();
        end
        send(items[4].wr, items[4].addr, items[4].data);
        chk("t4_full", 32'(req_ready), 0);
        for (int c = 0; c < 10; c++) begin
            cyc();
            chk("t5_no_mem_read", 32'(mem_read), 0);
            chk("t5_no_mem_write", 32'(mem_write), 0);
            chk("t5_rsp_held", 32'(rsp_valid), 1);
            chk("t5_rsp_addr", 32'(rsp_address), 32'h0020);
            chk("t5_still_full", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        acc5 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            acc5 = req_ready;
            cyc();
            if (acc5) break;
        end
        chk("t4_fifth_accepted", 32'(acc5), 1);
        drain("t4");

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            req_valid   = ($urandom_range(0, 9) < 6);
            req_write   = 1'($urandom);
            req_address = 16'($urandom_range(0, 31));
            req_data    = 8'($urandom);
            rsp_ready   = 1'($urandom);
            cyc();
        end
        drain("rand");

        // Reset while waiting for read data.
        rsp_ready = 1'b1;
        send(1'b0, 16'h0030, 8'h00);
        cyc();
        req_valid = 1'b0;
        cyc();
        chk("t6_mem_read", 32'(mem_read), 1);
        cyc();
        chk("t6_waiting", 32'(busy), 1);
        chk("t6_no_rsp_yet", 32'(rsp_valid), 0);
        rst = 1'b1;
        tick();
        chk_reset("t6_rst");
        exp_ops.delete();
        exp_rsp.delete();
        rsp_timer = 0;
        err_exp   = 0;
        rst = 1'b0;
        cyc();
        cyc();
        chk("t6_dropped", 32'(rsp_valid), 0);
        rsp_ready = 1'b0;
        send(1'b0, 16'h0011, 8'h00);
        cyc();
        req_valid = 1'b0;
        wait_rsp("t6");
        chk("t6_rsp_address", 32'(rsp_address), 32'h0011);
        drain("t6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
